pointwise_stream: RTL and testbench

- Parametrised successor of the 1x1 pointwise convolution unit. Computes an OCP-wide output channel tile from ICP-wide input channel slices over an output_size x output_size feature map.
- Runtime-configurable channel counts, shift and bias base. Valid/ready handshakes on the feature and output streams; loadable bias memory; two's-complement rounding and saturation.
- Sits between the depthwise stage / intermediate buffer and the P2P buffer.

---
 rtl/pointwise_stream.sv | 224 ++++++++++++++++++++++
 tb/tb_pointwise_stream.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pointwise_stream.sv
// pointwise_stream: streaming 1x1 convolution tile engine with bias, rounding requant and saturation.
// Define POINTWISE_RELU_EN to honour cfg_relu (clamp negative results to zero).
module pointwise_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int ICP        = 8,
  parameter int OCP        = 8,
  parameter int ACC_WIDTH  = 40,
  parameter int BIAS_DEPTH = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [7:0]                       cfg_output_size,
  input  logic [8:0]                       cfg_in_ch,
  input  logic [8:0]                       cfg_out_ch,
  input  logic [4:0]                       cfg_shift,
  input  logic [7:0]                       cfg_bias_base,
  input  logic                             cfg_relu,
  input  logic                             bias_wr_en,
  input  logic [7:0]                       bias_wr_addr,
  input  logic [2*DATA_WIDTH-1:0]          bias_wr_data,
  input  logic                             feat_valid,
  output logic                             feat_ready,
  input  logic [DATA_WIDTH*ICP-1:0]        feat_data,
  input  logic [DATA_WIDTH*ICP*OCP-1:0]    wgt_data,
  output logic [8:0]                       ic_sel,
  output logic [8:0]                       oc_sel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*OCP-1:0]        out_data,
  output logic [8:0]                       out_oc,
  output logic [7:0]                       out_h,
  output logic [7:0]                       out_w,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);
  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] MAXV = (ACC_WIDTH'(1) << (DW - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] MINV = -(ACC_WIDTH'(1) << (DW - 1));

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [8:0] oc;
    logic [7:0] h;
    logic [7:0] w;
    logic       first;
    logic       last;
    logic       mlast;
  } tag_t;

  state_t state_q, state_d;
  logic [7:0] size_q, base_q, w_q, h_q;
  logic [8:0] in_q, out_q, ic_q, oc_q;
  logic [4:0] shift_q;
  logic       cfg_err_q;
  logic       s0_v, s1_v, s2_v, s3_v;
  tag_t       s0_tag, s1_tag, s2_tag, s3_tag;
  logic       out_valid_q, out_last_q;
  logic [DW*OCP-1:0] out_data_q;
  logic [8:0] out_oc_q;
  logic [7:0] out_h_q, out_w_q;

  logic [PW-1:0]                bias_mem [BIAS_DEPTH];
  logic [DW*ICP-1:0]            s0_feat;
  logic [DW*ICP*OCP-1:0]        s0_wgt;
  logic signed [PW-1:0]         s1_prod [OCP*ICP];
  logic signed [ACC_WIDTH-1:0]  s1_sum [OCP];
  logic signed [ACC_WIDTH-1:0]  s2_sum [OCP];
  logic [PW-1:0]                s2_bias [OCP];
  logic signed [ACC_WIDTH-1:0]  acc_q [OCP];
  logic [DW-1:0]                qv [OCP];

  logic legal, stall, accept, ic_last, oc_last, w_last, h_last, beat_last;
  logic unused_ok;

  function automatic logic [DW-1:0] quant(input logic signed [ACC_WIDTH-1:0] a, input logic [4:0] sh);
    logic signed [ACC_WIDTH-1:0] r;
    r = a;
    if (sh != 5'd0) r = r + (ACC_WIDTH'(1) << (sh - 5'd1));
    r = r >>> sh;
    return (r > MAXV) ? MAXV[DW-1:0] : (r < MINV) ? MINV[DW-1:0] : r[DW-1:0];
  endfunction

  assign legal = cfg_output_size != 8'd0 && cfg_in_ch != 9'd0 && cfg_in_ch <= 9'd256 &&
                 (cfg_in_ch % 9'(ICP)) == 9'd0 && cfg_out_ch != 9'd0 && cfg_out_ch <= 9'd256 &&
                 (cfg_out_ch % 9'(OCP)) == 9'd0;
  assign stall      = out_valid_q && !out_ready;
  assign feat_ready = state_q == RUN && !stall;
  assign accept     = feat_valid && feat_ready;
  assign ic_last    = ic_q + 9'(ICP) == in_q;
  assign oc_last    = oc_q + 9'(OCP) == out_q;
  assign w_last     = w_q == size_q - 8'd1;
  assign h_last     = h_q == size_q - 8'd1;
  assign beat_last  = ic_last && oc_last && w_last && h_last;
  assign done = state_q == DRAIN && out_valid_q && out_last_q && out_ready && !s0_v && !s1_v && !s2_v && !s3_v;

  always_comb begin
    state_d = (state_q == IDLE && start && legal) ? RUN :
              (state_q == RUN && accept && beat_last) ? DRAIN :
              (state_q == DRAIN && done) ? IDLE : state_q;
  end

  always_comb begin
    for (int o = 0; o < OCP; o++) begin
      s1_sum[o] = '0;
      for (int k = 0; k < ICP; k++)
        s1_sum[o] = s1_sum[o] + {{(ACC_WIDTH-PW){s1_prod[o*ICP+k][PW-1]}}, s1_prod[o*ICP+k]};
    end
  end

`ifdef POINTWISE_RELU_EN
  logic relu_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) relu_q <= 1'b0;
    else if (state_q == IDLE && start && legal) relu_q <= cfg_relu;
  end
  always_comb begin
    for (int o = 0; o < OCP; o++) begin
      qv[o] = quant(acc_q[o], shift_q);
      qv[o] = (relu_q && qv[o][DW-1]) ? '0 : qv[o];
    end
  end
  assign unused_ok = s3_tag.first;
`else
  always_comb begin
    for (int o = 0; o < OCP; o++) qv[o] = quant(acc_q[o], shift_q);
  end
  assign unused_ok = s3_tag.first ^ cfg_relu;
`endif

  always_ff @(posedge clk) begin
    if (bias_wr_en && state_q == IDLE) bias_mem[bias_wr_addr] <= bias_wr_data;
  end

  // Datapath registers carry no reset; their valid bits live in the control block.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (accept) begin
        s0_feat <= feat_data;
        s0_wgt  <= wgt_data;
      end
      for (int o = 0; o < OCP; o++) begin
        for (int k = 0; k < ICP; k++)
          s1_prod[o*ICP+k] <= $signed(s0_feat[k*DW+:DW]) * $signed(s0_wgt[(o*ICP+k)*DW+:DW]);
        s2_sum[o]  <= s1_sum[o];
        s2_bias[o] <= bias_mem[base_q + s1_tag.oc[7:0] + 8'(o)];
        if (s2_v)
          acc_q[o] <= (s2_tag.first ? {{(ACC_WIDTH-PW){s2_bias[o][PW-1]}}, s2_bias[o]} : acc_q[o]) + s2_sum[o];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      size_q      <= '0;
      base_q      <= '0;
      in_q        <= '0;
      out_q       <= '0;
      shift_q     <= '0;
      ic_q        <= '0;
      oc_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      cfg_err_q   <= 1'b0;
      {s0_v, s1_v, s2_v, s3_v} <= '0;
      {s0_tag, s1_tag, s2_tag, s3_tag} <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_oc_q    <= '0;
      out_h_q     <= '0;
      out_w_q     <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= state_q == IDLE && start && !legal;
      if (state_q == IDLE && start && legal) begin
        size_q  <= cfg_output_size;
        in_q    <= cfg_in_ch;
        out_q   <= cfg_out_ch;
        shift_q <= cfg_shift;
        base_q  <= cfg_bias_base;
      end
      if (accept) begin
        ic_q <= ic_last ? '0 : ic_q + 9'(ICP);
        if (ic_last) oc_q <= oc_last ? '0 : oc_q + 9'(OCP);
        if (ic_last && oc_last) w_q <= w_last ? '0 : w_q + 8'd1;
        if (ic_last && oc_last && w_last) h_q <= h_last ? '0 : h_q + 8'd1;
      end
      if (!stall) begin
        s0_v   <= accept;
        s1_v   <= s0_v;
        s2_v   <= s1_v;
        s3_v   <= s2_v;
        s0_tag <= {oc_q, h_q, w_q, ic_q == 9'd0, ic_last, beat_last};
        s1_tag <= s0_tag;
        s2_tag <= s1_tag;
        s3_tag <= s2_tag;
        out_valid_q <= s3_v && s3_tag.last;
        if (s3_v && s3_tag.last) begin
          for (int o = 0; o < OCP; o++) out_data_q[o*DW+:DW] <= qv[o];
          out_oc_q   <= s3_tag.oc;
          out_h_q    <= s3_tag.h;
          out_w_q    <= s3_tag.w;
          out_last_q <= s3_tag.mlast;
        end
      end
    end
  end

  assign ic_sel    = ic_q;
  assign oc_sel    = oc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_oc    = out_oc_q;
  assign out_h     = out_h_q;
  assign out_w     = out_w_q;
  assign out_last  = out_valid_q && out_last_q;
  assign busy      = state_q != IDLE;
  assign cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_pointwise_stream.sv
// tb_pointwise_stream: directed scoreboard bench for pointwise_stream.
module tb_pointwise_stream;
  localparam int DW = 16;
  localparam int ICP = 8;
  localparam int OCP = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] cfg_output_size = '0, cfg_bias_base = '0;
  logic [8:0] cfg_in_ch = '0, cfg_out_ch = '0;
  logic [4:0] cfg_shift = '0;
  logic cfg_relu = 1'b0, bias_wr_en = 1'b0;
  logic [7:0] bias_wr_addr = '0;
  logic [2*DW-1:0] bias_wr_data = '0;
  logic feat_valid = 1'b0, feat_ready, out_valid, out_ready = 1'b1, out_last, busy, done, cfg_err;
  logic [DW*ICP-1:0] feat_data = '0;
  logic [DW*ICP*OCP-1:0] wgt_data = '0;
  logic [8:0] ic_sel, oc_sel, out_oc;
  logic [7:0] out_h, out_w;
  logic [DW*OCP-1:0] out_data;

  pointwise_stream dut (
    .clk(clk), .rst(rst), .start(start), .cfg_output_size(cfg_output_size), .cfg_in_ch(cfg_in_ch),
    .cfg_out_ch(cfg_out_ch), .cfg_shift(cfg_shift), .cfg_bias_base(cfg_bias_base), .cfg_relu(cfg_relu),
    .bias_wr_en(bias_wr_en), .bias_wr_addr(bias_wr_addr), .bias_wr_data(bias_wr_data),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data), .wgt_data(wgt_data),
    .ic_sel(ic_sel), .oc_sel(oc_sel), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_oc(out_oc), .out_h(out_h), .out_w(out_w), .out_last(out_last), .busy(busy), .done(done),
    .cfg_err(cfg_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*OCP-1:0] data;
    int oc;
    int h;
    int w;
    bit last;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0, tiles = 0, dones = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [DW*OCP-1:0] rep(int v);
    logic [DW*OCP-1:0] r;
    for (int o = 0; o < OCP; o++) r[o*DW+:DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [DW*ICP*OCP-1:0] wrep(int v);
    logic [DW*ICP*OCP-1:0] r;
    for (int i = 0; i < ICP*OCP; i++) r[i*DW+:DW] = v[DW-1:0];
    return r;
  endfunction

  task automatic push(logic [DW*OCP-1:0] d, int oc, int h, int w, bit last);
    exp_t e;
    e.data = d; e.oc = oc; e.h = h; e.w = w; e.last = last;
    q.push_back(e);
  endtask

  task automatic wbias(int a, int v);
    bias_wr_en = 1'b1; bias_wr_addr = 8'(a); bias_wr_data = 32'(v);
    @(negedge clk);
    bias_wr_en = 1'b0;
  endtask

  task automatic go(int size, int ic, int oc, int sh, int base, bit relu);
    cfg_output_size = 8'(size); cfg_in_ch = 9'(ic); cfg_out_ch = 9'(oc);
    cfg_shift = 5'(sh); cfg_bias_base = 8'(base); cfg_relu = relu; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(logic [DW*ICP-1:0] f, logic [DW*ICP*OCP-1:0] wv, int eic, int eoc);
    int n;
    feat_data = f; wgt_data = wv; feat_valid = 1'b1;
    #1;
    n = 0;
    while (!feat_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    if (!feat_ready) begin
      checks++; errors++;
      $display("FAIL beat_timeout actual=%0d required=ready", feat_ready);
    end
    chk("ic_sel", ic_sel, eic);
    chk("oc_sel", oc_sel, eoc);
    @(negedge clk);
    feat_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_queue", q.size(), 0);
  endtask

  task automatic test_simple();
    int k;
    go(1, 8, 8, 0, 0, 0);
    #1 chk("busy_run", busy, 1);
    push(rep(21), 0, 0, 0, 1);
    send(rep(1), wrep(2), 0, 0);
    k = 0;
    #1;
    while (!out_valid && k < 20) begin
      @(negedge clk); #1; k++;
    end
    chk("latency", k, 4);
    chk("out_last_flag", out_last, 1);
    wait_idle();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && out_valid && out_ready) begin
        tiles++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_tile actual=oc%0d,h%0d,w%0d required=none", out_oc, out_h, out_w);
        end else begin
          e = q.pop_front();
          chk("tile_data", out_data, e.data);
          chk("tile_oc", out_oc, e.oc);
          chk("tile_hw", {out_h, out_w}, {e.h[7:0], e.w[7:0]});
          chk("tile_last", out_last, e.last);
          if (out_last) chk("done_pulse", done, 1);
        end
      end
      if (!rst && done) dones++;
    end
  end

  initial begin
    logic [DW*OCP-1:0] snap, dq;
    logic [DW*ICP*OCP-1:0] wv;
    logic sv;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ready", feat_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_sel", {ic_sel, oc_sel}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) wbias(i, 5);
    test_simple();
    chk("done_count1", dones, 1);

    // two ic slices, two oc blocks, 2x2 map, with a downstream stall mid-run
    for (int c = 0; c < 16; c++) wbias(16 + c, 3 * c - 10);
    go(2, 16, 16, 0, 16, 0);
    fork
      begin
        for (int p = 0; p < 4; p++)
          for (int oc = 0; oc < 16; oc += 8) begin
            for (int o = 0; o < OCP; o++) dq[o*DW+:DW] = 16'(16 * (p + 1) + 3 * (oc + o) - 10);
            push(dq, oc, p / 2, p % 2, p == 3 && oc == 8);
            for (int ic = 0; ic < 16; ic += 8) send(rep(p + 1), wrep(1), ic, oc);
          end
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 snap = out_data; sv = out_valid;
        repeat (7) @(negedge clk);
        #1;
        chk("stall_data", out_data, snap);
        chk("stall_valid", out_valid, sv);
        chk("stall_ready", feat_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("tile_count", tiles, 9);
    chk("done_count2", dones, 2);

    // rounding shift and saturation
    for (int i = 0; i < 8; i++) wbias(32 + i, 0);
    for (int o = 0; o < OCP; o++)
      for (int k = 0; k < ICP; k++) wv[(o*ICP+k)*DW+:DW] = (o % 2 != 0) ? 16'hFFFF : 16'h0001;
    for (int o = 0; o < OCP; o++) dq[o*DW+:DW] = (o % 2 != 0) ? 16'hFFFF : 16'h0002;
    go(1, 8, 8, 2, 32, 0);
    push(dq, 0, 0, 0, 1);
    send(128'd6, wv, 0, 0);
    wait_idle();
    for (int o = 0; o < OCP; o++)
      for (int k = 0; k < ICP; k++) wv[(o*ICP+k)*DW+:DW] = (o < 4) ? 16'd128 : 16'hFF80;
    for (int o = 0; o < OCP; o++) dq[o*DW+:DW] = (o < 4) ? 16'h7FFF : 16'h8000;
    go(1, 8, 8, 0, 32, 0);
    push(dq, 0, 0, 0, 1);
    send(rep(1024), wv, 0, 0);
    wait_idle();

    // relu on a -3 result
    for (int i = 0; i < 8; i++) wbias(48 + i, -3);
    go(1, 8, 8, 0, 48, 1);
`ifdef POINTWISE_RELU_EN
    push(rep(0), 0, 0, 0, 1);
`else
    push(rep(-3), 0, 0, 0, 1);
`endif
    send('0, '0, 0, 0);
    wait_idle();

    // illegal configurations
    go(1, 12, 8, 0, 0, 0);
    #1 chk("err_pulse", cfg_err, 1);
    chk("err_idle", busy, 0);
    @(negedge clk); #1;
    chk("err_clear", cfg_err, 0);
    go(0, 8, 8, 0, 0, 0);
    #1 chk("err_size0", cfg_err, 1);
    chk("err_size0_idle", busy, 0);
    @(negedge clk);

    // reset mid-run, then a fresh run
    go(2, 16, 16, 0, 16, 0);
    for (int i = 0; i < 3; i++) send(rep(1), wrep(1), (i % 2) * 8, (i / 2) * 8);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", feat_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_sel", {ic_sel, oc_sel}, 0);
    chk("mid_rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_simple();
    chk("done_count_final", dones, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
